// File: rtl/asrv32_fetch.sv
// ASRV32 instruction fetch stage: PC, single-outstanding imem port, IF/ID register, skid buffer.
// Optional ASRV32_FETCH_MISALIGN_EN: misaligned redirects raise o_misaligned_ifid with a NOP.
module asrv32_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst_ifid,
    output logic [31:0] o_pc_ifid,
    output logic        o_ce,
`ifdef ASRV32_FETCH_MISALIGN_EN
    output logic        o_misaligned_ifid,
`endif
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_change_pc,
    input  logic [31:0] i_next_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_HOLD,
        S_DISCARD,
        S_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        stb_q, stb_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_ifid_q, pc_ifid_d;
    logic        ce_q, ce_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_vld_q, skid_vld_d;
`ifdef ASRV32_FETCH_MISALIGN_EN
    logic        mis_q, mis_d;
`endif

    logic        ack;
    logic [31:0] redir_pc;
    logic        redir_mis;
    logic [31:0] pc_inc;

    assign ack    = stb_q & i_ack_inst;
    assign pc_inc = pc_q + 32'd4;

`ifdef ASRV32_FETCH_MISALIGN_EN
    assign redir_pc  = i_next_pc;
    assign redir_mis = (i_next_pc[1:0] != 2'b00);
`else
    assign redir_pc  = i_next_pc & 32'hFFFF_FFFC;
    assign redir_mis = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iaddr_d     = iaddr_q;
        stb_d       = stb_q;
        inst_d      = inst_q;
        pc_ifid_d   = pc_ifid_q;
        ce_d        = ce_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_vld_d  = skid_vld_q;
`ifdef ASRV32_FETCH_MISALIGN_EN
        mis_d       = mis_q;
`endif
        if (i_change_pc) begin
            pc_d       = redir_pc;
            ce_d       = 1'b0;
            skid_vld_d = 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
            mis_d      = redir_mis;
`endif
            // An unacked request must still complete on the bus; its word is dropped later.
            if (stb_q && !i_ack_inst) begin
                state_d = S_DISCARD;
            end else if (redir_mis) begin
                iaddr_d = redir_pc;
                stb_d   = 1'b0;
                state_d = S_IDLE;
            end else begin
                iaddr_d = redir_pc;
                stb_d   = 1'b1;
                state_d = S_FETCH;
            end
            if (redir_mis) begin
                ce_d      = 1'b1;
                pc_ifid_d = i_next_pc;
                inst_d    = NOP;
            end
        end else begin
            if (i_flush) begin
                ce_d       = 1'b0;
                skid_vld_d = 1'b0;
            end
            case (state_q)
                S_START: begin
                    stb_d   = 1'b1;
                    iaddr_d = pc_q;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (!i_flush) begin
                        if (i_stall) begin
                            if (ack) begin
                                skid_inst_d = i_inst;
                                skid_pc_d   = pc_q;
                                skid_vld_d  = 1'b1;
                                pc_d        = pc_inc;
                                iaddr_d     = pc_inc;
                                stb_d       = 1'b0;
                                state_d     = S_HOLD;
                            end
                        end else if (ack) begin
                            inst_d    = i_inst;
                            pc_ifid_d = pc_q;
                            ce_d      = 1'b1;
                            pc_d      = pc_inc;
                            iaddr_d   = pc_inc;
`ifdef ASRV32_FETCH_MISALIGN_EN
                            mis_d     = 1'b0;
`endif
                        end else begin
                            ce_d = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    // A flush empties the buffer, so there is nothing left to wait for.
                    if (i_flush || !i_stall) begin
                        skid_vld_d = 1'b0;
                        stb_d      = 1'b1;
                        iaddr_d    = pc_q;
                        state_d    = S_FETCH;
                        if (!i_flush) begin
                            inst_d    = skid_inst_q;
                            pc_ifid_d = skid_pc_q;
                            ce_d      = skid_vld_q;
`ifdef ASRV32_FETCH_MISALIGN_EN
                            mis_d     = 1'b0;
`endif
                        end
                    end
                end
                S_DISCARD: begin
                    if (!i_flush && !i_stall) ce_d = 1'b0;
                    if (ack) begin
                        iaddr_d = pc_q;
                        stb_d   = 1'b1;
                        state_d = S_FETCH;
`ifdef ASRV32_FETCH_MISALIGN_EN
                        if (pc_q[1:0] != 2'b00) begin
                            stb_d   = 1'b0;
                            state_d = S_IDLE;
                        end
`endif
                    end
                end
                S_IDLE: begin
                    if (!i_flush && !i_stall) ce_d = 1'b0;
                end
                default: state_d = S_START;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_START;
            pc_q        <= PC_RESET;
            iaddr_q     <= PC_RESET;
            stb_q       <= 1'b0;
            inst_q      <= 32'd0;
            pc_ifid_q   <= 32'd0;
            ce_q        <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            skid_vld_q  <= 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iaddr_q     <= iaddr_d;
            stb_q       <= stb_d;
            inst_q      <= inst_d;
            pc_ifid_q   <= pc_ifid_d;
            ce_q        <= ce_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_vld_q  <= skid_vld_d;
`ifdef ASRV32_FETCH_MISALIGN_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign o_iaddr     = iaddr_q;
    assign o_stb_inst  = stb_q;
    assign o_inst_ifid = inst_q;
    assign o_pc_ifid   = pc_ifid_q;
    assign o_ce        = ce_q;
`ifdef ASRV32_FETCH_MISALIGN_EN
    assign o_misaligned_ifid = mis_q;
`endif

endmodule

// File: tb/tb_asrv32_fetch.sv
// Directed bench for asrv32_fetch with a small configurable-latency instruction memory.
module tb_asrv32_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] iaddr;
    logic        stb;
    logic        ack;
    logic [31:0] inst;
    logic [31:0] inst_ifid;
    logic [31:0] pc_ifid;
    logic        ce;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        change_pc = 1'b0;
    logic [31:0] next_pc = 32'd0;
`ifdef ASRV32_FETCH_MISALIGN_EN
    logic        mis;
`endif

    int   lat = 1;
    logic hold_ack = 1'b0;
    int   cnt;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    asrv32_fetch dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_iaddr     (iaddr),
        .o_stb_inst  (stb),
        .i_ack_inst  (ack),
        .i_inst      (inst),
        .o_inst_ifid (inst_ifid),
        .o_pc_ifid   (pc_ifid),
        .o_ce        (ce),
`ifdef ASRV32_FETCH_MISALIGN_EN
        .o_misaligned_ifid (mis),
`endif
        .i_stall     (stall),
        .i_flush     (flush),
        .i_change_pc (change_pc),
        .i_next_pc   (next_pc)
    );

    always #5 clk = ~clk;

    // Memory: ack after 'lat' cycles of strobe; word content derived from the address.
    assign ack  = stb && (cnt >= lat - 1) && !hold_ack;
    assign inst = (iaddr == 32'd0) ? 32'h0000_0093 :
                  (iaddr == 32'd4) ? 32'h0010_0113 : {iaddr[15:0], 16'h0513};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= 0;
        else if (!stb || ack) cnt <= 0;
        else                  cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        lat = l;
        hold_ack = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        change_pc = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_pc_ifid", pc_ifid, 32'd0);
        chk("rst_inst_ifid", inst_ifid, 32'd0);
`ifdef ASRV32_FETCH_MISALIGN_EN
        chk("rst_mis", {31'd0, mis}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic       exp_ce_b [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_pc_b [6] = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 32'd8};

    initial begin
        #3;
        // Section A: single-cycle memory.
        do_reset(1);
        step();
        chk("A_e1_stb", {31'd0, stb}, 32'd1);
        chk("A_e1_ce", {31'd0, ce}, 32'd0);
        chk("A_e1_iaddr", iaddr, 32'd0);
        step();
        chk("A_e2_ce", {31'd0, ce}, 32'd1);
        chk("A_e2_pc", pc_ifid, 32'd0);
        chk("A_e2_inst", inst_ifid, 32'h0000_0093);
        chk("A_e2_iaddr", iaddr, 32'd4);
        step();
        chk("A_e3_ce", {31'd0, ce}, 32'd1);
        chk("A_e3_pc", pc_ifid, 32'd4);
        chk("A_e3_inst", inst_ifid, 32'h0010_0113);
        chk("A_e3_iaddr", iaddr, 32'd8);

        // Section B: two-cycle memory, IF/ID valid every other cycle.
        do_reset(2);
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("B_ce_%0d", i), {31'd0, ce}, {31'd0, exp_ce_b[i]});
            chk($sformatf("B_pc_%0d", i), pc_ifid, exp_pc_b[i]);
        end

        // Section C: stall/skid, redirect with request in flight, flush, wrap, low-bit redirect.
        do_reset(1);
        step();
        step();
        step();
        chk("C_pre_pc", pc_ifid, 32'd4);
        stall = 1'b1;
        step();
        chk("C_stall_pc", pc_ifid, 32'd4);
        chk("C_stall_ce", {31'd0, ce}, 32'd1);
        chk("C_stall_stb", {31'd0, stb}, 32'd0);
        chk("C_stall_iaddr", iaddr, 32'd12);
        step();
        step();
        chk("C_hold_pc", pc_ifid, 32'd4);
        chk("C_hold_stb", {31'd0, stb}, 32'd0);
        stall = 1'b0;
        step();
        chk("C_rel_pc", pc_ifid, 32'd8);
        chk("C_rel_inst", inst_ifid, 32'h0008_0513);
        chk("C_rel_ce", {31'd0, ce}, 32'd1);
        chk("C_rel_stb", {31'd0, stb}, 32'd1);
        chk("C_rel_iaddr", iaddr, 32'd12);
        step();
        chk("C_next_pc", pc_ifid, 32'd12);
        chk("C_next_iaddr", iaddr, 32'd16);

        hold_ack = 1'b1;
        step();
        chk("R_bubble_ce", {31'd0, ce}, 32'd0);
        change_pc = 1'b1;
        next_pc = 32'h0000_0100;
        step();
        change_pc = 1'b0;
        chk("R_disc_iaddr", iaddr, 32'd16);
        chk("R_disc_stb", {31'd0, stb}, 32'd1);
        chk("R_disc_ce", {31'd0, ce}, 32'd0);
        hold_ack = 1'b0;
        step();
        chk("R_drop_ce", {31'd0, ce}, 32'd0);
        chk("R_new_iaddr", iaddr, 32'h0000_0100);
        step();
        chk("R_tgt_ce", {31'd0, ce}, 32'd1);
        chk("R_tgt_pc", pc_ifid, 32'h0000_0100);
        chk("R_tgt_inst", inst_ifid, 32'h0100_0513);
        chk("R_tgt_iaddr", iaddr, 32'h0000_0104);

        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("F_ce", {31'd0, ce}, 32'd0);
        chk("F_iaddr", iaddr, 32'h0000_0104);
        chk("F_pc_hold", pc_ifid, 32'h0000_0100);
        step();
        chk("F_next_ce", {31'd0, ce}, 32'd1);
        chk("F_next_pc", pc_ifid, 32'h0000_0104);
        chk("F_next_iaddr", iaddr, 32'h0000_0108);

        change_pc = 1'b1;
        next_pc = 32'hFFFF_FFFC;
        step();
        change_pc = 1'b0;
        chk("W_redir_ce", {31'd0, ce}, 32'd0);
        chk("W_redir_iaddr", iaddr, 32'hFFFF_FFFC);
        step();
        chk("W_ce", {31'd0, ce}, 32'd1);
        chk("W_pc", pc_ifid, 32'hFFFF_FFFC);
        chk("W_inst", inst_ifid, 32'hFFFC_0513);
        chk("W_wrap_iaddr", iaddr, 32'd0);

        change_pc = 1'b1;
        next_pc = 32'h0000_0102;
        step();
        change_pc = 1'b0;
`ifdef ASRV32_FETCH_MISALIGN_EN
        chk("M_ce", {31'd0, ce}, 32'd1);
        chk("M_pc", pc_ifid, 32'h0000_0102);
        chk("M_inst", inst_ifid, 32'h0000_0013);
        chk("M_mis", {31'd0, mis}, 32'd1);
        chk("M_stb", {31'd0, stb}, 32'd0);
        step();
        chk("M_idle_ce", {31'd0, ce}, 32'd0);
        chk("M_idle_stb", {31'd0, stb}, 32'd0);
        chk("M_idle_mis", {31'd0, mis}, 32'd1);
`else
        chk("L_ce", {31'd0, ce}, 32'd0);
        chk("L_iaddr", iaddr, 32'h0000_0100);
        chk("L_stb", {31'd0, stb}, 32'd1);
        step();
        chk("L_next_ce", {31'd0, ce}, 32'd1);
        chk("L_next_pc", pc_ifid, 32'h0000_0100);
`endif

        // Asynchronous reset in the middle of activity.
        do_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
